dma_ctrl_nch: RTL and testbench
===============================

// Module: dma_ctrl_nch
// PURPOSE
//  - Parametrised multi-channel 8257-style DMA controller. Successor to the fixed 4-channel video DMA.
//  - Adds: configurable channel count and address width, per-channel mask register, autoload on every channel,
//    TC status register, and TC-stop.
//  - Sits between the 8080 CPU bus (hrq/hlda) and the memory mux; serves video (CRT drq) and future disk/tape channels.
// PARAMETERS
//  CHANNELS  4   number of channels, 1..8; channel 0 has the highest fixed priority
//  AW        16  output address width, 8..16; upper programmed address bits above AW are discarded
//  CNTW      14  transfer-count width; count register bits [15:14] are always the transfer type
// PORTS
//  clk       in   1         system clock
//  reset_n   in   1         asynchronous, active-low reset
//  ce        in   1         clock enable (CPU f2 strobe); the state machine advances only on clk edges with ce=1
//  iaddr     in   5         register select: [4]=0 -> {chan[2:0],reg[0]} (0=addr,1=count); 0x10 mode, 0x11 status, 0x12 mask
//  idata     in   8         CPU write data
//  iwe_n     in   1         CPU write strobe; one write is performed per low period (falling-edge detect)
//  ird_n     in   1         CPU read strobe
//  odata     out  8         read data (combinational from iaddr)
//  drq       in   CHANNELS  device requests, level sensitive
//  hlda      in   1         hold acknowledge from CPU
//  hrq       out  1         hold request to CPU
//  dack      out  CHANNELS  one-hot acknowledge of the serviced channel
//  oaddr     out  AW        DMA memory address
//  ord_n     out  1         memory read strobe
//  owe_n     out  1         memory write strobe
//  oiord_n   out  1         I/O read strobe
//  oiowe_n   out  1         I/O write strobe
//  tc        out  1         terminal count, high during S3/S4 of the final byte
// BEHAVIOUR
//  - Reset: hrq=0, dack=0, tc=0, all strobes=1, oaddr=0, mode=0, mask=0, TC flags=0, byte flip-flop=LSB, state=IDLE.
//  - Register writes (16-bit): a byte flip-flop selects LSB then MSB. It toggles on each channel-register write.
//    It is cleared by reset and by any mode write.
//  - Every channel write also loads that channel's shadow register (autoload source).
//  - Reads: addr/count registers return the byte selected by the flip-flop and toggle it.
//  - Status read: odata={TC flags}, zero-extended. Flags clear on the rising edge of ird_n.
//  - Mode register bits: [0] ROT (rotating priority); [1] AUTOLOAD; [2] TCSTOP. Other bits read back as 0.
//  - Mask register: bit k enables channel k; mask bits at index >= CHANNELS are ignored.
//  - Type field: count[15:14]: 00 verify (no strobes), 01 write (oiord_n + owe_n), 10 read (ord_n + oiowe_n), 11 illegal (treated as verify).
//  - FSM, one state per ce:
//    - IDLE: enters REQ when any masked drq is high; hrq=1.
//    - REQ: waits for hlda=1, latches the winning channel, goes to S1.
//    - S1: drives oaddr and dack.
//    - S2: asserts the read strobe.
//    - S3: asserts the write strobe; tc=1 if count[CNTW-1:0]==0.
//    - S4: deasserts strobes; increments address (mod 2^AW); decrements count (wraps to all ones).
//    - After S4: go to S1 if any masked drq is still high (demand mode, bus kept); otherwise go to IDLE and drop hrq.
//  - Count N transfers N+1 bytes.
//  - Priority: fixed = lowest index wins. ROT = after servicing channel k, channel (k+1) mod CHANNELS is highest.
//  - On TC:
//    - The TC flag of the channel is set.
//    - If AUTOLOAD: address and count reload from the shadow register in S4, and the mask bit is kept.
//    - Else if TCSTOP: the mask bit is cleared in S4.
//  - hlda falls during S1..S3: strobes and dack deassert on the next edge, no address/count update, state -> IDLE.
//  - CPU write to the active channel during S1..S4: the CPU value wins and the S4 update is discarded for that register.
//  - drq dropping after REQ latch: the current byte still completes.
//  - Reset asserted mid-transfer: all outputs go inactive immediately (asynchronous); no partial register update.
// TESTING
//  - Program ch2 addr=0x1234, count=0x8002 (read, 3 bytes), mask=0x04; hold drq[2]=1, hlda=1 after 2 ce.
//    -> 3 cycles, oaddr 0x1234..0x1236, tc high on the 3rd, status read=0x04 then 0x00.
//  - drq[0] and drq[3] asserted together, ROT=0 -> ch0 served first. ROT=1 after a ch0 transfer -> ch3 before ch0.
//  - AUTOLOAD=1, ch1 addr=0x4000, count=0x4001: 4 transfers -> oaddr 0x4000,0x4001,0x4000,0x4001, mask bit stays set.
//  - TCSTOP=1, AUTOLOAD=0, count=0 -> single byte, mask bit 1 cleared, hrq drops, later drq[1] ignored.
//  - hlda deasserted in S2 -> ord_n=1 next edge, oaddr/count unchanged, FSM back to IDLE then re-requests.
//  - reset_n pulsed low during S3 -> hrq=0, all strobes=1 same cycle; mode, mask and flip-flop read back cleared.

Source files
------------

// File: rtl/dma_ctrl_nch.sv
// rtl/dma_ctrl_nch.sv - parametrised N-channel 8257-style DMA controller
// Demand-mode transfers with fixed/rotating priority, autoload, TC status and TC-stop.
module dma_ctrl_nch #(
  parameter int CHANNELS = 4,
  parameter int AW       = 16,
  parameter int CNTW     = 14
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                ce,
  input  logic [4:0]          iaddr,
  input  logic [7:0]          idata,
  input  logic                iwe_n,
  input  logic                ird_n,
  output logic [7:0]          odata,
  input  logic [CHANNELS-1:0] drq,
  input  logic                hlda,
  output logic                hrq,
  output logic [CHANNELS-1:0] dack,
  output logic [AW-1:0]       oaddr,
  output logic                ord_n,
  output logic                owe_n,
  output logic                oiord_n,
  output logic                oiowe_n,
  output logic                tc
);

  typedef enum logic [2:0] {ST_IDLE, ST_REQ, ST_S1, ST_S2, ST_S3, ST_S4} state_e;

  state_e      state_q, state_d;
  logic [2:0]  cur_q, cur_d;
  logic [2:0]  prio_q, prio_d;
  logic [2:0]  mode_q, mode_d;
  logic [7:0]  mask_q, mask_d;
  logic [7:0]  tcf_q, tcf_d;
  logic        ff_q, ff_d;
  logic        we_prev_q, rd_prev_q;

  // Channel datapath registers are sized for the full 8-entry register map;
  // entries at or above CHANNELS are never written and read back as 0.
  logic [15:0] addr_q [8];
  logic [15:0] addr_d [8];
  logic [15:0] cnt_q  [8];
  logic [15:0] cnt_d  [8];
  logic [15:0] sha_q  [8];
  logic [15:0] sha_d  [8];
  logic [15:0] shc_q  [8];
  logic [15:0] shc_d  [8];

  logic [7:0]  drq8, req8, req_next;
  logic [2:0]  sel_ch;
  logic        sel_ok, we_fall, rd_rise, active, is_tc;
  logic [15:0] cur_cnt, cur_addr, addr_inc, cnt_dec;
  logic [1:0]  xtype;
  logic [7:0]  onehot;

  function automatic logic [2:0] arb(input logic [7:0] req, input logic [2:0] base);
    logic [2:0] w;
    logic       found;
    int         idx;
    w     = '0;
    found = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      idx = (int'(base) + i) % CHANNELS;
      if (!found && req[3'(idx)]) begin
        w     = 3'(idx);
        found = 1'b1;
      end
    end
    return w;
  endfunction

  function automatic logic [15:0] set_byte(input logic [15:0] v, input logic hi, input logic [7:0] b);
    return hi ? {b, v[7:0]} : {v[15:8], b};
  endfunction

  always_comb begin
    drq8 = '0;
    for (int i = 0; i < CHANNELS; i++) drq8[i] = drq[i];
  end

  assign req8     = drq8 & mask_q;
  assign sel_ch   = iaddr[3:1];
  assign sel_ok   = ({1'b0, sel_ch} < 4'(CHANNELS));
  assign we_fall  = we_prev_q & ~iwe_n;
  assign rd_rise  = ~rd_prev_q & ird_n;
  assign active   = (state_q == ST_S1) || (state_q == ST_S2) || (state_q == ST_S3) || (state_q == ST_S4);
  assign cur_cnt  = cnt_q[cur_q];
  assign cur_addr = addr_q[cur_q];
  assign xtype    = cur_cnt[15:14];
  assign is_tc    = (cur_cnt[CNTW-1:0] == '0);

  always_comb begin
    addr_inc            = cur_addr;
    addr_inc[AW-1:0]    = cur_addr[AW-1:0] + AW'(1);
    cnt_dec             = cur_cnt;
    cnt_dec[CNTW-1:0]   = cur_cnt[CNTW-1:0] - CNTW'(1);
  end

  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    prio_d   = prio_q;
    mode_d   = mode_q;
    mask_d   = mask_q;
    tcf_d    = tcf_q;
    ff_d     = ff_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    sha_d    = sha_q;
    shc_d    = shc_q;
    req_next = '0;

    if (rd_rise && iaddr == 5'h11) tcf_d = '0;
    if (rd_rise && !iaddr[4] && sel_ok) ff_d = ~ff_q;

    if (ce) begin
      case (state_q)
        ST_IDLE: if (|req8) state_d = ST_REQ;
        ST_REQ: begin
          if (hlda) begin
            if (|req8) begin
              cur_d   = arb(req8, mode_q[0] ? prio_q : 3'd0);
              state_d = ST_S1;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        ST_S1: state_d = hlda ? ST_S2 : ST_IDLE;
        ST_S2: state_d = hlda ? ST_S3 : ST_IDLE;
        ST_S3: state_d = hlda ? ST_S4 : ST_IDLE;
        ST_S4: begin
          addr_d[cur_q] = addr_inc;
          cnt_d[cur_q]  = cnt_dec;
          if (is_tc) begin
            tcf_d[cur_q] = 1'b1;
            if (mode_q[1]) begin
              addr_d[cur_q] = sha_q[cur_q];
              cnt_d[cur_q]  = shc_q[cur_q];
            end else if (mode_q[2]) begin
              mask_d[cur_q] = 1'b0;
            end
          end
          prio_d   = (int'(cur_q) + 1 >= CHANNELS) ? 3'd0 : cur_q + 3'd1;
          // Re-arbitrate against the post-TC mask so a TC-stopped channel loses the bus.
          req_next = drq8 & mask_d;
          if (hlda && |req_next) begin
            cur_d   = arb(req_next, mode_q[0] ? prio_d : 3'd0);
            state_d = ST_S1;
          end else begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // CPU writes come last so they override any same-cycle S4 update.
    if (we_fall) begin
      if (!iaddr[4]) begin
        if (sel_ok) begin
          if (!iaddr[0]) begin
            addr_d[sel_ch] = set_byte(addr_q[sel_ch], ff_q, idata);
            sha_d[sel_ch]  = set_byte(sha_q[sel_ch], ff_q, idata);
          end else begin
            cnt_d[sel_ch]  = set_byte(cnt_q[sel_ch], ff_q, idata);
            shc_d[sel_ch]  = set_byte(shc_q[sel_ch], ff_q, idata);
          end
          ff_d = ~ff_q;
        end
      end else if (iaddr[3:0] == 4'h0) begin
        mode_d = idata[2:0];
        ff_d   = 1'b0;
      end else if (iaddr[3:0] == 4'h2) begin
        for (int i = 0; i < CHANNELS; i++) mask_d[i] = idata[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cur_q     <= '0;
      prio_q    <= '0;
      mode_q    <= '0;
      mask_q    <= '0;
      tcf_q     <= '0;
      ff_q      <= 1'b0;
      we_prev_q <= 1'b1;
      rd_prev_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      prio_q    <= prio_d;
      mode_q    <= mode_d;
      mask_q    <= mask_d;
      tcf_q     <= tcf_d;
      ff_q      <= ff_d;
      we_prev_q <= iwe_n;
      rd_prev_q <= ird_n;
    end
  end

  // Programmed values survive reset; the FSM cannot touch them while in reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      addr_q[i] <= addr_d[i];
      cnt_q[i]  <= cnt_d[i];
      sha_q[i]  <= sha_d[i];
      shc_q[i]  <= shc_d[i];
    end
  end

  always_comb begin
    odata = 8'h00;
    if (!iaddr[4]) begin
      if (sel_ok) begin
        if (!iaddr[0]) odata = ff_q ? addr_q[sel_ch][15:8] : addr_q[sel_ch][7:0];
        else           odata = ff_q ? cnt_q[sel_ch][15:8]  : cnt_q[sel_ch][7:0];
      end
    end else begin
      case (iaddr[3:0])
        4'h0:    odata = {5'b00000, mode_q};
        4'h1:    odata = tcf_q;
        4'h2:    odata = mask_q;
        default: odata = 8'h00;
      endcase
    end
  end

  assign onehot  = active ? (8'b1 << cur_q) : 8'b0;
  assign dack    = onehot[CHANNELS-1:0];
  assign hrq     = (state_q != ST_IDLE);
  assign oaddr   = active ? cur_addr[AW-1:0] : '0;
  assign ord_n   = !(((state_q == ST_S2) || (state_q == ST_S3)) && xtype == 2'b10);
  assign oiord_n = !(((state_q == ST_S2) || (state_q == ST_S3)) && xtype == 2'b01);
  assign oiowe_n = !((state_q == ST_S3) && xtype == 2'b10);
  assign owe_n   = !((state_q == ST_S3) && xtype == 2'b01);
  assign tc      = ((state_q == ST_S3) || (state_q == ST_S4)) && is_tc;

endmodule

// File: tb/tb_dma_ctrl_nch.sv
// tb/tb_dma_ctrl_nch.sv - directed self-checking bench for dma_ctrl_nch
module tb_dma_ctrl_nch;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ce = 1'b1;
  logic [4:0] iaddr = '0;
  logic [7:0] idata = '0;
  logic       iwe_n = 1'b1;
  logic       ird_n = 1'b1;
  logic [7:0] odata;
  logic [3:0] drq = '0;
  logic       hlda = 1'b0;
  logic       hrq;
  logic [3:0] dack;
  logic [15:0] oaddr;
  logic       ord_n, owe_n, oiord_n, oiowe_n, tc;
  int         n_checks = 0;
  int         n_err = 0;
  logic [7:0] rd;
  logic       ok;

  dma_ctrl_nch #(.CHANNELS(4), .AW(16), .CNTW(14)) dut (
    .clk(clk), .reset_n(reset_n), .ce(ce), .iaddr(iaddr), .idata(idata),
    .iwe_n(iwe_n), .ird_n(ird_n), .odata(odata), .drq(drq), .hlda(hlda),
    .hrq(hrq), .dack(dack), .oaddr(oaddr), .ord_n(ord_n), .owe_n(owe_n),
    .oiord_n(oiord_n), .oiowe_n(oiowe_n), .tc(tc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cpu_wr(input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    iaddr = a; idata = d; iwe_n = 1'b0;
    @(negedge clk);
    iwe_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wr16(input logic [4:0] a, input logic [15:0] v);
    cpu_wr(a, v[7:0]);
    cpu_wr(a, v[15:8]);
  endtask

  task automatic cpu_rd(input logic [4:0] a, output logic [7:0] d);
    @(negedge clk);
    iaddr = a; ird_n = 1'b0;
    @(negedge clk);
    d = odata;
    ird_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_dack(output logic found);
    found = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      @(negedge clk);
      if (dack != 4'b0) found = 1'b1;
    end
    if (!found) check("dack_timeout", 32'd0, 32'd1);
  endtask

  // Returns at the S4 negedge of the byte.
  task automatic watch_byte(input string tag, input logic [15:0] ea, input logic [3:0] ed,
                            input int ty, input logic etc);
    logic       f;
    logic [3:0] s2, s3;
    s2 = (ty == 2) ? 4'b0111 : (ty == 1) ? 4'b1101 : 4'b1111;
    s3 = (ty == 2) ? 4'b0110 : (ty == 1) ? 4'b1001 : 4'b1111;
    wait_dack(f);
    if (f) begin
      check({tag, "_dack"}, {28'd0, dack}, {28'd0, ed});
      check({tag, "_addr"}, {16'd0, oaddr}, {16'd0, ea});
      @(negedge clk);
      check({tag, "_s2"}, {28'd0, ord_n, owe_n, oiord_n, oiowe_n}, {28'd0, s2});
      @(negedge clk);
      check({tag, "_s3"}, {28'd0, ord_n, owe_n, oiord_n, oiowe_n}, {28'd0, s3});
      check({tag, "_tc3"}, {31'd0, tc}, {31'd0, etc});
      @(negedge clk);
      check({tag, "_tc4"}, {31'd0, tc}, {31'd0, etc});
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_hrq", {31'd0, hrq}, 32'd0);
    check("rst_dack", {28'd0, dack}, 32'd0);
    check("rst_strobes", {27'd0, ord_n, owe_n, oiord_n, oiowe_n, tc}, 32'h1e);
    check("rst_oaddr", {16'd0, oaddr}, 32'd0);
    reset_n = 1'b1;
    cpu_rd(5'h10, rd); check("rst_mode", {24'd0, rd}, 32'd0);
    cpu_rd(5'h12, rd); check("rst_mask", {24'd0, rd}, 32'd0);

    // ch2 read transfer, 3 bytes; ce gating first
    wr16(5'h04, 16'h1234);
    wr16(5'h05, 16'h8002);
    cpu_wr(5'h12, 8'h04);
    ce = 1'b0; drq = 4'b0100;
    repeat (3) @(negedge clk);
    check("ce_hold", {31'd0, hrq}, 32'd0);
    ce = 1'b1;
    @(negedge clk);
    check("t1_hrq", {31'd0, hrq}, 32'd1);
    repeat (2) @(negedge clk);
    hlda = 1'b1;
    watch_byte("t1b0", 16'h1234, 4'b0100, 2, 1'b0);
    watch_byte("t1b1", 16'h1235, 4'b0100, 2, 1'b0);
    watch_byte("t1b2", 16'h1236, 4'b0100, 2, 1'b1);
    drq = 4'b0000;
    @(negedge clk);
    check("t1_idle", {27'd0, hrq, dack}, 32'd0);
    cpu_rd(5'h11, rd); check("t1_stat", {24'd0, rd}, 32'h04);
    cpu_rd(5'h11, rd); check("t1_stat_clr", {24'd0, rd}, 32'h00);
    cpu_rd(5'h04, rd); check("t1_addr_lo", {24'd0, rd}, 32'h37);
    cpu_rd(5'h04, rd); check("t1_addr_hi", {24'd0, rd}, 32'h12);
    cpu_rd(5'h05, rd); check("t1_cnt_lo", {24'd0, rd}, 32'hff);
    cpu_rd(5'h05, rd); check("t1_cnt_hi", {24'd0, rd}, 32'hbf);

    // fixed priority then rotating
    cpu_wr(5'h10, 8'h00);
    wr16(5'h00, 16'h0100); wr16(5'h01, 16'h8000);
    wr16(5'h06, 16'h0300); wr16(5'h07, 16'h8000);
    cpu_wr(5'h12, 8'h09);
    drq = 4'b1001;
    watch_byte("fx0", 16'h0100, 4'b0001, 2, 1'b1);
    drq = 4'b1000;
    watch_byte("fx3", 16'h0300, 4'b1000, 2, 1'b1);
    drq = 4'b0000;
    @(negedge clk);
    cpu_rd(5'h11, rd); check("fx_stat", {24'd0, rd}, 32'h09);
    cpu_wr(5'h10, 8'h01);
    drq = 4'b0001;
    watch_byte("rot0a", 16'h0101, 4'b0001, 2, 1'b0);
    drq = 4'b0000;
    @(negedge clk);
    drq = 4'b1001;
    watch_byte("rot3", 16'h0301, 4'b1000, 2, 1'b0);
    drq = 4'b0001;
    watch_byte("rot0b", 16'h0102, 4'b0001, 2, 1'b0);
    drq = 4'b0000;
    @(negedge clk);

    // autoload on ch1, write type
    cpu_wr(5'h10, 8'h02);
    wr16(5'h02, 16'h4000); wr16(5'h03, 16'h4001);
    cpu_wr(5'h12, 8'h02);
    drq = 4'b0010;
    watch_byte("al0", 16'h4000, 4'b0010, 1, 1'b0);
    watch_byte("al1", 16'h4001, 4'b0010, 1, 1'b1);
    watch_byte("al2", 16'h4000, 4'b0010, 1, 1'b0);
    watch_byte("al3", 16'h4001, 4'b0010, 1, 1'b1);
    drq = 4'b0000;
    @(negedge clk);
    cpu_rd(5'h12, rd); check("al_mask", {24'd0, rd}, 32'h02);
    cpu_rd(5'h11, rd); check("al_stat", {24'd0, rd}, 32'h02);

    // TC-stop, verify type, single byte
    cpu_wr(5'h10, 8'h04);
    wr16(5'h02, 16'h5000); wr16(5'h03, 16'h0000);
    cpu_wr(5'h12, 8'h02);
    drq = 4'b0010;
    watch_byte("ts", 16'h5000, 4'b0010, 0, 1'b1);
    @(negedge clk);
    check("ts_hrq_drop", {31'd0, hrq}, 32'd0);
    cpu_rd(5'h12, rd); check("ts_mask", {24'd0, rd}, 32'h00);
    repeat (4) @(negedge clk);
    check("ts_ignored", {31'd0, hrq}, 32'd0);
    drq = 4'b0000;

    // hold ack lost in S2
    cpu_wr(5'h10, 8'h00);
    wr16(5'h04, 16'h2000); wr16(5'h05, 16'h8005);
    cpu_wr(5'h12, 8'h04);
    drq = 4'b0100;
    wait_dack(ok);
    @(negedge clk);
    check("ab_s2_rd", {31'd0, ord_n}, 32'd0);
    hlda = 1'b0;
    @(negedge clk);
    check("ab_release", {27'd0, ord_n, dack}, 32'h10);
    @(negedge clk);
    check("ab_rereq", {31'd0, hrq}, 32'd1);
    hlda = 1'b1;
    watch_byte("ab", 16'h2000, 4'b0100, 2, 1'b0);
    drq = 4'b0000;
    @(negedge clk);
    cpu_rd(5'h05, rd); check("ab_cnt_lo", {24'd0, rd}, 32'h04);
    cpu_rd(5'h05, rd); check("ab_cnt_hi", {24'd0, rd}, 32'h80);

    // asynchronous reset in S3
    cpu_wr(5'h10, 8'h03);
    cpu_wr(5'h12, 8'h04);
    cpu_rd(5'h04, rd); check("rs_pre_lo", {24'd0, rd}, 32'h01);
    drq = 4'b0100;
    wait_dack(ok);
    @(negedge clk);
    @(negedge clk);
    check("rs_s3_rd", {31'd0, ord_n}, 32'd0);
    reset_n = 1'b0;
    #1;
    check("rs_outs", {26'd0, hrq, dack, ord_n}, 32'h01);
    check("rs_strobes", {28'd0, ord_n, owe_n, oiord_n, oiowe_n}, 32'hf);
    drq = 4'b0000; hlda = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    cpu_rd(5'h10, rd); check("rs_mode", {24'd0, rd}, 32'h00);
    cpu_rd(5'h12, rd); check("rs_mask", {24'd0, rd}, 32'h00);
    cpu_rd(5'h04, rd); check("rs_ff_lo", {24'd0, rd}, 32'h01);
    cpu_rd(5'h04, rd); check("rs_ff_hi", {24'd0, rd}, 32'h20);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
